// File: rtl/dcache_pkg.sv
// Shared types and field positions for the L1 data-cache sequencer.
// Tag word layout: [24]=valid, [23]=dirty, [22:0]=address tag.
package dcache_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int LINE_WIDTH = 256;
  localparam int TAG_WIDTH  = 25;
  localparam int WORD_WIDTH = 32;
  localparam int WORD_IDX_W = 3;

  localparam int TAG_VALID_BIT = 24;
  localparam int TAG_DIRTY_BIT = 23;
  localparam int TAG_ADDR_MSB  = 22;
  localparam int SET_LSB       = 5;
  localparam int SET_W         = 4;
  localparam int WORD_LSB      = 2;
  localparam int ADDR_TAG_W    = TAG_ADDR_MSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RF,
    FILL,
    REPLAY
  } state_t;

  function automatic logic [TAG_WIDTH-1:0] make_tag(input logic dirty,
                                                    input logic [ADDR_TAG_W-1:0] addr_tag);
    return {1'b1, dirty, addr_tag};
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Word select and word insert on a cache line; one instance serves
// both the hit path and the refill merge.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_WIDTH-1:0] src_line,
  input  logic [WORD_IDX_W-1:0] word_idx,
  input  logic [WORD_WIDTH-1:0] wr_word,
  output logic [WORD_WIDTH-1:0] rd_word,
  output logic [LINE_WIDTH-1:0] merged_line
);

  always_comb begin
    rd_word     = src_line[int'(word_idx)*WORD_WIDTH +: WORD_WIDTH];
    merged_line = src_line;
    merged_line[int'(word_idx)*WORD_WIDTH +: WORD_WIDTH] = wr_word;
  end

endmodule

// File: rtl/dcache_controller.sv
// L1 data-cache sequencer: same-cycle hits, write-back + refill + replay on miss.
// Optional performance counters are built when DCACHE_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | serving hits; a miss latches the request and victim
// WB     | writing the dirty victim line back to memory
// RF     | reading the requested line from memory
// FILL   | writing the refilled (possibly store-merged) line into the SRAM
// REPLAY | SRAM now hits; load data returned, stall released
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int MEM_ADDR_W = ADDR_WIDTH,
  parameter int LINE_W     = LINE_WIDTH,
  parameter int TAG_W      = TAG_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [MEM_ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]           cpu_data_i,
  output logic [31:0]           cpu_data_o,
  output logic                  cpu_stall_o,
  output logic                  sram_enable_o,
  output logic                  sram_write_o,
  output logic [SET_W-1:0]      sram_addr_o,
  output logic [TAG_W-1:0]      sram_tag_o,
  output logic [LINE_W-1:0]     sram_data_o,
  input  logic [TAG_W-1:0]      sram_tag_i,
  input  logic [LINE_W-1:0]     sram_data_i,
  input  logic                  sram_hit_i,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0]     mem_data_o,
  input  logic [LINE_W-1:0]     mem_data_i,
  input  logic                  mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]           perf_hit_o,
  output logic [31:0]           perf_miss_o,
  output logic [31:0]           perf_wb_o
`endif
);

  state_t state;

  logic [ADDR_TAG_W-1:0] tag_q;
  logic [SET_W-1:0]      set_q;
  logic [WORD_IDX_W-1:0] word_q;
  logic                  we_q;
  logic [31:0]           data_q;
  logic [ADDR_TAG_W-1:0] victim_tag_q;
  logic [LINE_W-1:0]     victim_line_q;
  logic [LINE_W-1:0]     refill_q;

  logic [ADDR_TAG_W-1:0] cpu_tag;
  logic [SET_W-1:0]      cpu_set;
  logic [WORD_IDX_W-1:0] cpu_word;
  logic                  unused_byte_offset;

  assign cpu_tag            = cpu_addr_i[MEM_ADDR_W-1 -: ADDR_TAG_W];
  assign cpu_set            = cpu_addr_i[SET_LSB +: SET_W];
  assign cpu_word           = cpu_addr_i[WORD_LSB +: WORD_IDX_W];
  assign unused_byte_offset = ^cpu_addr_i[WORD_LSB-1:0];

  logic victim_dirty;
  assign victim_dirty = sram_tag_i[TAG_VALID_BIT] & sram_tag_i[TAG_DIRTY_BIT];

  // IDLE merges the live request into the hit line; later states use latched copies.
  logic [LINE_W-1:0]     m_src;
  logic [WORD_IDX_W-1:0] m_idx;
  logic [31:0]           m_wr;
  logic [31:0]           m_rd;
  logic [LINE_W-1:0]     m_merged;

  assign m_src = (state == FILL) ? refill_q : sram_data_i;
  assign m_idx = (state == IDLE) ? cpu_word : word_q;
  assign m_wr  = (state == IDLE) ? cpu_data_i : data_q;

  dcache_word_merge u_merge (
    .src_line    (m_src),
    .word_idx    (m_idx),
    .wr_word     (m_wr),
    .rd_word     (m_rd),
    .merged_line (m_merged)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      tag_q         <= '0;
      set_q         <= '0;
      word_q        <= '0;
      we_q          <= 1'b0;
      data_q        <= '0;
      victim_tag_q  <= '0;
      victim_line_q <= '0;
      refill_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_i && !sram_hit_i) begin
            tag_q         <= cpu_tag;
            set_q         <= cpu_set;
            word_q        <= cpu_word;
            we_q          <= cpu_we_i;
            data_q        <= cpu_data_i;
            victim_tag_q  <= sram_tag_i[TAG_ADDR_MSB:0];
            victim_line_q <= sram_data_i;
            state         <= victim_dirty ? WB : RF;
          end
        end
        WB: begin
          if (mem_ack_i) state <= RF;
        end
        RF: begin
          if (mem_ack_i) begin
            refill_q <= mem_data_i;
            state    <= FILL;
          end
        end
        FILL:    state <= REPLAY;
        REPLAY:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are combinational so hits and miss stalls take effect in the request cycle.
  always_comb begin
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_addr_o   = '0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          sram_enable_o = cpu_req_i;
          sram_addr_o   = cpu_set;
          sram_tag_o    = make_tag(cpu_we_i, cpu_tag);
          if (cpu_req_i && sram_hit_i) begin
            if (cpu_we_i) begin
              sram_write_o = 1'b1;
              sram_data_o  = m_merged;
            end else begin
              cpu_data_o = m_rd;
            end
          end else if (cpu_req_i) begin
            cpu_stall_o = 1'b1;
          end
        end
        WB: begin
          cpu_stall_o  = 1'b1;
          sram_addr_o  = set_q;
          sram_tag_o   = make_tag(we_q, tag_q);
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {victim_tag_q, set_q, 5'b0};
          mem_data_o   = victim_line_q;
        end
        RF: begin
          cpu_stall_o  = 1'b1;
          sram_addr_o  = set_q;
          sram_tag_o   = make_tag(we_q, tag_q);
          mem_enable_o = 1'b1;
          mem_addr_o   = {tag_q, set_q, 5'b0};
        end
        FILL: begin
          cpu_stall_o   = 1'b1;
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_addr_o   = set_q;
          sram_tag_o    = make_tag(we_q, tag_q);
          sram_data_o   = we_q ? m_merged : refill_q;
        end
        REPLAY: begin
          sram_enable_o = 1'b1;
          sram_addr_o   = set_q;
          sram_tag_o    = make_tag(we_q, tag_q);
          cpu_data_o    = we_q ? 32'h0 : m_rd;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_hit_o  <= '0;
      perf_miss_o <= '0;
      perf_wb_o   <= '0;
    end else begin
      if (state == IDLE && cpu_req_i && sram_hit_i && perf_hit_o != '1)
        perf_hit_o <= perf_hit_o + 32'd1;
      if (state == IDLE && cpu_req_i && !sram_hit_i && perf_miss_o != '1)
        perf_miss_o <= perf_miss_o + 32'd1;
      if (state == WB && mem_ack_i && perf_wb_o != '1)
        perf_wb_o <= perf_wb_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed scoreboard bench for dcache_controller; expected SRAM writes,
// memory requests and load returns are queued by the driver and popped by a monitor.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, sram_enable_o, sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_hit_i;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  perf_hit_o, perf_miss_o, perf_wb_o;
`endif

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cpu_req_i     (cpu_req_i),
    .cpu_we_i      (cpu_we_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_data_o    (cpu_data_o),
    .cpu_stall_o   (cpu_stall_o),
    .sram_enable_o (sram_enable_o),
    .sram_write_o  (sram_write_o),
    .sram_addr_o   (sram_addr_o),
    .sram_tag_o    (sram_tag_o),
    .sram_data_o   (sram_data_o),
    .sram_tag_i    (sram_tag_i),
    .sram_data_i   (sram_data_i),
    .sram_hit_i    (sram_hit_i),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .perf_hit_o    (perf_hit_o),
    .perf_miss_o   (perf_miss_o),
    .perf_wb_o     (perf_wb_o)
`endif
  );

  typedef struct {
    logic [24:0]  tag;
    logic [255:0] data;
    logic [3:0]   set;
  } sram_wr_t;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_req_t;

  sram_wr_t    exp_sram[$];
  mem_req_t    exp_mem[$];
  logic [31:0] exp_load[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic hit,
                       input logic [24:0] vtag, input logic [255:0] line);
    cpu_req_i   = req;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_data_i  = wdata;
    sram_hit_i  = hit;
    sram_tag_i  = vtag;
    sram_data_i = line;
  endtask

  task automatic mem_serve(input int lat, input logic [255:0] rdata);
    int n;
    n = 0;
    while (!mem_enable_o && n < 20) begin
      step();
      n++;
    end
    check("mem_request_seen", {255'b0, mem_enable_o}, 256'd1);
    if (mem_enable_o) begin
      repeat (lat - 1) step();
      mem_ack_i  = 1'b1;
      mem_data_i = rdata;
      step();
      mem_ack_i  = 1'b0;
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // Monitor: pops expectations whenever the DUT presents an observable transaction.
  logic prev_en  = 1'b0;
  logic prev_ack = 1'b0;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (sram_write_o) begin
        if (exp_sram.size() == 0) check("unexpected_sram_write", {255'b0, sram_write_o}, 256'd0);
        else begin
          sram_wr_t e;
          e = exp_sram.pop_front();
          check("sram_tag", {231'b0, sram_tag_o}, {231'b0, e.tag});
          check("sram_data", sram_data_o, e.data);
          check("sram_addr", {252'b0, sram_addr_o}, {252'b0, e.set});
        end
      end
      if (mem_enable_o && (!prev_en || prev_ack)) begin
        if (exp_mem.size() == 0) check("unexpected_mem_req", {255'b0, mem_enable_o}, 256'd0);
        else begin
          mem_req_t m;
          m = exp_mem.pop_front();
          check("mem_write", {255'b0, mem_write_o}, {255'b0, m.wr});
          check("mem_addr", {224'b0, mem_addr_o}, {224'b0, m.addr});
          if (m.wr) check("mem_data", mem_data_o, m.data);
        end
      end
      if (cpu_req_i && !cpu_we_i && !cpu_stall_o) begin
        if (exp_load.size() == 0) check("unexpected_load", {224'b0, cpu_data_o}, 256'd0);
        else check("load_data", {224'b0, cpu_data_o}, {224'b0, exp_load.pop_front()});
      end
    end
    prev_en  <= mem_enable_o;
    prev_ack <= mem_ack_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [255:0] l1, l2, l3, l4, l4m;

  initial begin
    l1 = mk_line(32'h1000_0000);
    l1[63:32] = 32'hDEADBEEF;
    l2 = l1;
    l2[95:64] = 32'hCAFEF00D;
    l3 = mk_line(32'h3000_0000);
    l4 = mk_line(32'h4000_0000);
    l4m = l4;
    l4m[127:96] = 32'h12345678;

    rst_i = 1'b1;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 25'h0, '0);
    step();
    check("rst_stall", {255'b0, cpu_stall_o}, 256'd0);
    check("rst_mem_en", {255'b0, mem_enable_o}, 256'd0);
    check("rst_sram_wr", {255'b0, sram_write_o}, 256'd0);
    rst_i = 1'b0;
    step();

    // load miss, clean victim, 3-cycle refill
    drive(1'b1, 1'b0, 32'h0000_0204, 32'h0, 1'b0, 25'h0, '0);
    exp_mem.push_back('{wr: 1'b0, addr: 32'h0000_0200, data: '0});
    exp_sram.push_back('{tag: 25'h100_0001, data: l1, set: 4'd0});
    exp_load.push_back(32'hDEADBEEF);
    #1 check("miss_stall", {255'b0, cpu_stall_o}, 256'd1);
    step();
    mem_serve(3, l1);
    check("fill_stall", {255'b0, cpu_stall_o}, 256'd1);
    step();
    sram_hit_i = 1'b1;
    sram_data_i = l1;
    #1 check("replay_stall", {255'b0, cpu_stall_o}, 256'd0);
    step();
    cpu_req_i = 1'b0;
    step();

    // store hit
    drive(1'b1, 1'b1, 32'h0000_0208, 32'hCAFEF00D, 1'b1, 25'h100_0001, l1);
    exp_sram.push_back('{tag: 25'h180_0001, data: l2, set: 4'd0});
    #1 check("store_hit_stall", {255'b0, cpu_stall_o}, 256'd0);
    step();
    cpu_req_i = 1'b0;
    step();

    // load miss, dirty victim: write-back then refill
    drive(1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b0, 25'h180_0001, l2);
    exp_mem.push_back('{wr: 1'b1, addr: 32'h0000_0200, data: l2});
    exp_mem.push_back('{wr: 1'b0, addr: 32'h0000_0400, data: '0});
    exp_sram.push_back('{tag: 25'h100_0002, data: l3, set: 4'd0});
    exp_load.push_back(32'h3000_0000);
    step();
    mem_serve(2, '0);
    mem_serve(2, l3);
    step();
    sram_hit_i = 1'b1;
    sram_data_i = l3;
    step();
    cpu_req_i = 1'b0;
    step();

    // store miss, clean valid victim, 1-cycle refill
    drive(1'b1, 1'b1, 32'h0000_0A6C, 32'h12345678, 1'b0, 25'h100_0007, l3);
    exp_mem.push_back('{wr: 1'b0, addr: 32'h0000_0A60, data: '0});
    exp_sram.push_back('{tag: 25'h180_0005, data: l4m, set: 4'd3});
    step();
    mem_serve(1, l4);
    step();
    sram_hit_i = 1'b1;
    sram_data_i = l4m;
    #1 check("store_replay_stall", {255'b0, cpu_stall_o}, 256'd0);
    step();
    cpu_req_i = 1'b0;
    step();
`ifdef DCACHE_PERF_CNT_EN
    check("perf_hit", {224'b0, perf_hit_o}, 256'd1);
    check("perf_miss", {224'b0, perf_miss_o}, 256'd3);
    check("perf_wb", {224'b0, perf_wb_o}, 256'd1);
`endif

    // reset during refill
    drive(1'b1, 1'b0, 32'h0000_1044, 32'h0, 1'b0, 25'h0, '0);
    exp_mem.push_back('{wr: 1'b0, addr: 32'h0000_1040, data: '0});
    step();
    step();
    check("rf_mem_en", {255'b0, mem_enable_o}, 256'd1);
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    #1;
    check("abort_mem_en", {255'b0, mem_enable_o}, 256'd0);
    check("abort_stall", {255'b0, cpu_stall_o}, 256'd0);
    step();
    check("abort_mem_addr", {224'b0, mem_addr_o}, 256'd0);
    check("abort_sram_en", {255'b0, sram_enable_o}, 256'd0);
    check("abort_sram_wr", {255'b0, sram_write_o}, 256'd0);
    rst_i = 1'b0;
    step();
    check("post_rst_mem_en", {255'b0, mem_enable_o}, 256'd0);
    drive(1'b1, 1'b0, 32'h0000_0204, 32'h0, 1'b1, 25'h100_0001, l1);
    exp_load.push_back(32'hDEADBEEF);
    #1 check("post_rst_hit_stall", {255'b0, cpu_stall_o}, 256'd0);
    step();
    cpu_req_i = 1'b0;
    step();

    // spurious ack while idle
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    check("spurious_mem_en", {255'b0, mem_enable_o}, 256'd0);
    check("spurious_stall", {255'b0, cpu_stall_o}, 256'd0);
`ifdef DCACHE_PERF_CNT_EN
    check("perf_hit_after", {224'b0, perf_hit_o}, 256'd1);
    check("perf_miss_after", {224'b0, perf_miss_o}, 256'd0);
    check("perf_wb_after", {224'b0, perf_wb_o}, 256'd0);
`endif
    drive(1'b1, 1'b0, 32'h0000_0A6C, 32'h0, 1'b1, 25'h180_0005, l4m);
    exp_load.push_back(32'h12345678);
    #1 check("idle_hit_stall", {255'b0, cpu_stall_o}, 256'd0);
    step();
    cpu_req_i = 1'b0;
    repeat (3) step();

    check("sram_queue_empty", 256'(exp_sram.size()), 256'd0);
    check("mem_queue_empty", 256'(exp_mem.size()), 256'd0);
    check("load_queue_empty", 256'(exp_load.size()), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Sequencer for the 2-way, 16-set, 256-bit-line L1 data-cache SRAM.
- Accepts single-word load/store requests from the CPU MEM stage.
- Serves hits in the same cycle.
- On a miss: writes back the dirty victim, refills the line from data memory, then replays the request.
- Sits between the pipeline MEM stage, the dcache SRAM and the off-chip data-memory model.

Parameters:
- MEM_ADDR_W, 32, CPU/memory byte-address width
- LINE_W, 256, cache line width in bits
- TAG_W, 25, SRAM tag word: [24]=valid, [23]=dirty, [22:0]=address tag

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cpu_req_i  in  1  load or store valid this cycle
- cpu_we_i  in  1  1=store, 0=load
- cpu_addr_i  in  32  byte address: [31:9] tag, [8:5] set, [4:2] word, [1:0] ignored
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data, valid when cpu_req_i & !cpu_we_i & !cpu_stall_o
- cpu_stall_o  out  1  pipeline stall
- sram_enable_o  out  1  SRAM enable
- sram_write_o  out  1  SRAM write strobe
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  tag to SRAM
- sram_data_o  out  256  line to SRAM
- sram_tag_i  in  25  victim tag on miss
- sram_data_i  in  256  hit line or victim line
- sram_hit_i  in  1  hit flag
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1=write-back, 0=refill read
- mem_addr_o  out  32  line address, [4:0]=0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Reset: state=IDLE; all outputs 0 (cpu_stall_o=0, mem_enable_o=0, sram_write_o=0). Reset mid-transaction aborts immediately. Memory must ignore an unacknowledged request dropped by reset.
- sram_enable_o = cpu_req_i in IDLE; forced 1 in FILL.
- sram_addr_o = latched set index outside IDLE.
- sram_tag_o = {1'b1, dirty, addr[31:9]}.
- IDLE, read hit (sram_hit_i=1): cpu_data_o = sram_data_i word [addr[4:2]], combinational. cpu_stall_o=0. No state change.
- IDLE, write hit: in the same cycle, sram_write_o=1 and sram_data_o = hit line with word addr[4:2] replaced by cpu_data_i, dirty=1. cpu_stall_o=0.
- IDLE, miss:
  - cpu_stall_o=1 combinationally.
  - Latch addr, we, data, and victim tag/line from sram_tag_i/sram_data_i.
  - Go to WB if victim valid&dirty, else to RF.
- WB:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {victim tag[22:0], set, 5'b0}; mem_data_o = latched victim line.
  - On mem_ack_i go to RF.
- RF:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {latched tag, set, 5'b0}.
  - On mem_ack_i, latch mem_data_i and go to FILL.
- FILL:
  - One cycle: sram_write_o=1, sram_data_o = refill line.
  - If the latched op is a store, merge cpu_data_i into the line and write tag dirty=1; otherwise dirty=0.
  - Go to REPLAY.
- REPLAY: one cycle; the SRAM now hits. cpu_stall_o=0, cpu_data_o served from sram_data_i. Return to IDLE.
- Stall:
  - cpu_stall_o=1 in WB, RF and FILL, and in IDLE on a miss.
  - Minimum miss penalty: clean victim = RF(≥1) + FILL + REPLAY; dirty victim adds WB(≥1).
- Timing: mem_enable_o deasserts the cycle after mem_ack_i. mem_ack_i is ignored outside WB/RF.
- Request stability: cpu_req_i, cpu_addr_i and cpu_data_i are held stable by the stalled pipeline. The controller still uses its latched copies.
- Victim selection belongs to the SRAM (LRU); the controller never chooses a way.

Optional Feature:
- DCACHE_PERF_CNT_EN defined:
  - Adds outputs perf_hit_o[31:0], perf_miss_o[31:0], perf_wb_o[31:0], all reset to 0.
  - perf_hit_o increments on an IDLE hit.
  - perf_miss_o increments on the IDLE→WB/RF transition.
  - perf_wb_o increments on WB ack.
  - Counters saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - state enum {IDLE, WB, RF, FILL, REPLAY};
  - field constants TAG_VALID_BIT=24, TAG_DIRTY_BIT=23, TAG_ADDR_MSB=22, SET_LSB=5, SET_W=4, WORD_LSB=2;
  - line/word widths.
- One sub-module: dcache_word_merge (combinational word select + word insert on a 256-bit line), shared by the hit path and FILL.

Test Plan:
- Reset then load 0x0000_0204 with SRAM miss, victim clean, memory ack after 3 cycles with line word1=0xDEADBEEF -> no write-back; RF 3 cycles, FILL writes tag valid=1/dirty=0; REPLAY returns 0xDEADBEEF; stall drops.
- Store 0xCAFEF00D to 0x0000_0208 on hit -> same-cycle sram_write_o=1, word2 replaced, dirty=1, no stall.
- Load to 0x0000_0400 (set 0, different tag) with dirty victim tag 0x000001 -> WB to mem_addr 0x0000_0200 with victim line, then RF from 0x0000_0400, FILL, REPLAY.
- Store miss with clean victim -> FILL line has the stored word merged, tag dirty=1, and memory receives no write.
- Assert rst_i during RF with mem_enable_o=1 -> next cycle all outputs 0, state IDLE; subsequent hit served normally.
- Spurious mem_ack_i in IDLE -> no state change, no SRAM write; with DCACHE_PERF_CNT_EN defined, counters unchanged.
